life_engine: RTL and testbench

- Parametrised Game-of-Life engine with a double-buffered cell map, generation pacing, cursor editing and pixel colour generation for the 640x480 VGA path.
- Sits between the PS/2 pointer decoder and the VGA timing block.
- Generalised over grid size, cell size, rule masks and edge topology.
- Adds run/step/clear control, a generation counter, a paced update and a registered colour output.

---
 rtl/life_engine.sv | 266 ++++++++++++++++++++++++++
 tb/tb_life_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_engine.sv
// Game-of-Life engine: double-buffered cell map, paced generations, cursor editing and VGA pixel colour.
// Optional change detection that halts run mode on a static map: define LIFE_AUTO_STOP_EN.
module life_engine #(
  parameter int         GRID_W        = 32,
  parameter int         GRID_H        = 24,
  parameter int         CELL_SIZE     = 20,
  parameter int         GEN_DIV       = 25000000,
  parameter logic [8:0] BIRTH_MASK    = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK  = 9'b000001100,
  parameter int         WRAP          = 1,
  parameter logic [11:0] COLOR_LIVE    = 12'h0F0,
  parameter logic [11:0] COLOR_EMPTY   = 12'hFFF,
  parameter logic [11:0] COLOR_POINTER = 12'h0C8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic        step,
  input  logic        clear,
  input  logic        pointer_ready,
  input  logic [8:0]  pointer_delta_x,
  input  logic [8:0]  pointer_delta_y,
  input  logic        pointer_select,
  input  logic [9:0]  x_position,
  input  logic [8:0]  y_position,
  input  logic        inside_video,
  output logic [11:0] color,
  output logic [15:0] generation,
  output logic        busy
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int PIX_W = GRID_W * CELL_SIZE;
  localparam int PIX_H = GRID_H * CELL_SIZE;
  localparam int DIV_W = $clog2(GEN_DIV);
  localparam int CX_W  = $clog2(GRID_W);
  localparam int CY_W  = $clog2(GRID_H);
  localparam logic signed [10:0] X_MAX = 11'(PIX_W - 1);
  localparam logic signed [10:0] Y_MAX = 11'(PIX_H - 1);
  localparam logic [10:0] X_LIM = 11'(PIX_W);
  localparam logic [10:0] Y_LIM = 11'(PIX_H);
  localparam logic [CY_W-1:0]  LAST_ROW = CY_W'(GRID_H - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(GEN_DIV - 2);

  typedef logic [GRID_H-1:0][GRID_W-1:0] grid_t;
  typedef enum logic [1:0] {IDLE, WAIT, UPDATE, CLEAR} state_t;

  function automatic logic [CELLS-1:0] glider_map();
    logic [CELLS-1:0] g;
    g = '0;
    for (int i = 0; i < 5; i++) begin
      int cx, cy;
      cx = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 0 : (i == 3) ? 1 : 2;
      cy = (i == 0) ? 0 : (i == 1) ? 1 : 2;
      if (cx < GRID_W && cy < GRID_H) g[cy*GRID_W + cx] = 1'b1;
    end
    return g;
  endfunction

  localparam grid_t GLIDER = glider_map();

  state_t           state_reg, state_next;
  grid_t            map_0_reg, map_1_reg;
  grid_t            active, next_grid, cursor_mask;
  logic             map_index_reg;
  logic [DIV_W-1:0] divider_reg;
  logic [15:0]      generation_reg;
  logic [CY_W-1:0]  clear_row_reg;
  logic [9:0]       cursor_x_reg, cursor_x_next;
  logic [8:0]       cursor_y_reg, cursor_y_next;
  logic [11:0]      color_reg, color_next;
  logic [CX_W-1:0]  cur_cx, pix_cx;
  logic [CY_W-1:0]  cur_cy, pix_cy;
  logic             toggle_en, in_grid;
  logic             halt, no_change;

  assign active    = map_index_reg ? map_1_reg : map_0_reg;
  assign toggle_en = pointer_select && !clear && (state_reg != CLEAR);

  // Neighbour counts are resolved at elaboration: each cell sees its eight fixed neighbours.
  genvar gi, gj, gk;
  generate
    for (gi = 0; gi < GRID_H; gi++) begin : g_row
      for (gj = 0; gj < GRID_W; gj++) begin : g_col
        logic [7:0] nb;
        logic [3:0] count;
        for (gk = 0; gk < 9; gk++) begin : g_nb
          if (gk != 4) begin : g_use
            localparam int RX = gj + (gk % 3) - 1;
            localparam int RY = gi + (gk / 3) - 1;
            localparam int BI = (gk < 4) ? gk : gk - 1;
            if (WRAP == 0 && (RX < 0 || RX >= GRID_W || RY < 0 || RY >= GRID_H)) begin : g_edge
              assign nb[BI] = 1'b0;
            end else begin : g_cell
              assign nb[BI] = active[(RY + GRID_H) % GRID_H][(RX + GRID_W) % GRID_W];
            end
          end
        end
        assign count = 4'(nb[0]) + 4'(nb[1]) + 4'(nb[2]) + 4'(nb[3])
                     + 4'(nb[4]) + 4'(nb[5]) + 4'(nb[6]) + 4'(nb[7]);
        assign next_grid[gi][gj] = active[gi][gj] ? SURVIVE_MASK[count] : BIRTH_MASK[count];
      end
    end
  endgenerate

`ifdef LIFE_AUTO_STOP_EN
  logic changed;
  logic halt_reg;
  assign changed   = |(next_grid ^ active);
  assign no_change = !changed;
  assign halt      = halt_reg;

  // Halt latches after a static generation and is released by any user activity.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      halt_reg <= 1'b0;
    end else if (!run || step || clear || toggle_en) begin
      halt_reg <= 1'b0;
    end else if (state_reg == UPDATE && !changed) begin
      halt_reg <= 1'b1;
    end
  end
`else
  assign no_change = 1'b0;
  assign halt      = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (clear)              state_next = CLEAR;
        else if (run && !halt)  state_next = WAIT;
        else if (step)          state_next = UPDATE;
      end
      WAIT: begin
        if (clear)                        state_next = CLEAR;
        else if (!run)                    state_next = IDLE;
        else if (divider_reg == DIV_LAST) state_next = UPDATE;
      end
      UPDATE: begin
        if (clear)                  state_next = CLEAR;
        else if (run && !no_change) state_next = WAIT;
        else                        state_next = IDLE;
      end
      CLEAR: begin
        if (!clear && clear_row_reg == LAST_ROW) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Divider sits at zero outside WAIT so every entry into WAIT starts a fresh period.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                divider_reg <= '0;
    else if (state_reg == WAIT)  divider_reg <= divider_reg + 1'b1;
    else                         divider_reg <= '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      map_index_reg  <= 1'b0;
      generation_reg <= '0;
      clear_row_reg  <= '0;
    end else begin
      case (state_reg)
        UPDATE: begin
          map_index_reg  <= ~map_index_reg;
          generation_reg <= generation_reg + 16'd1;
        end
        CLEAR: begin
          if (clear) begin
            clear_row_reg <= '0;
          end else if (clear_row_reg == LAST_ROW) begin
            clear_row_reg  <= '0;
            generation_reg <= '0;
            map_index_reg  <= 1'b0;
          end else begin
            clear_row_reg <= clear_row_reg + 1'b1;
          end
        end
        default: clear_row_reg <= '0;
      endcase
    end
  end

  always_comb begin
    cursor_mask = '0;
    cursor_mask[cur_cy][cur_cx] = 1'b1;
  end

  // A toggle landing in the UPDATE cycle is folded into the freshly written map.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      map_0_reg <= GLIDER;
      map_1_reg <= '0;
    end else begin
      case (state_reg)
        CLEAR: begin
          map_0_reg[clear_row_reg] <= '0;
          map_1_reg[clear_row_reg] <= '0;
        end
        UPDATE: begin
          if (map_index_reg) map_0_reg <= next_grid ^ (toggle_en ? cursor_mask : '0);
          else               map_1_reg <= next_grid ^ (toggle_en ? cursor_mask : '0);
        end
        default: begin
          if (toggle_en) begin
            if (map_index_reg) map_1_reg <= map_1_reg ^ cursor_mask;
            else               map_0_reg <= map_0_reg ^ cursor_mask;
          end
        end
      endcase
    end
  end

  always_comb begin
    logic signed [10:0] dx, dy, sx, sy;
    dx = pointer_delta_x[8] ? -$signed({3'b000, pointer_delta_x[7:0]}) : $signed({3'b000, pointer_delta_x[7:0]});
    dy = pointer_delta_y[8] ? -$signed({3'b000, pointer_delta_y[7:0]}) : $signed({3'b000, pointer_delta_y[7:0]});
    sx = $signed({1'b0, cursor_x_reg}) + dx;
    sy = $signed({2'b00, cursor_y_reg}) + dy;
    cursor_x_next = (sx < 0) ? 10'd0 : (sx > X_MAX) ? X_MAX[9:0] : sx[9:0];
    cursor_y_next = (sy < 0) ? 9'd0  : (sy > Y_MAX) ? Y_MAX[8:0] : sy[8:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cursor_x_reg <= 10'(PIX_W / 2);
      cursor_y_reg <= 9'(PIX_H / 2);
    end else if (pointer_ready) begin
      cursor_x_reg <= cursor_x_next;
      cursor_y_reg <= cursor_y_next;
    end
  end

  assign cur_cx  = CX_W'(cursor_x_reg / 10'(CELL_SIZE));
  assign cur_cy  = CY_W'(cursor_y_reg / 9'(CELL_SIZE));
  assign pix_cx  = CX_W'(x_position / 10'(CELL_SIZE));
  assign pix_cy  = CY_W'(y_position / 9'(CELL_SIZE));
  assign in_grid = ({1'b0, x_position} < X_LIM) && ({2'b00, y_position} < Y_LIM);

  always_comb begin
    color_next = 12'h000;
    if (inside_video && in_grid) begin
      if (active[pix_cy][pix_cx])                  color_next = COLOR_LIVE;
      else if (pix_cx == cur_cx && pix_cy == cur_cy) color_next = COLOR_POINTER;
      else                                         color_next = COLOR_EMPTY;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) color_reg <= 12'h000;
    else          color_reg <= color_next;
  end

  assign color      = color_reg;
  assign generation = generation_reg;
  assign busy       = (state_reg == CLEAR);

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine: a toroidal and a bounded instance share stimulus and are read back via pixel colour.
module tb_life_engine;
  localparam logic [11:0] LIVE  = 12'h0F0;
  localparam logic [11:0] EMPTY = 12'hFFF;
  localparam logic [11:0] PTR   = 12'h0C8;

  logic        clock = 1'b0, reset_n = 1'b0;
  logic        run = 1'b0, step = 1'b0, clear = 1'b0;
  logic        pointer_ready = 1'b0, pointer_select = 1'b0, inside_video = 1'b0;
  logic [8:0]  pointer_delta_x = '0, pointer_delta_y = '0;
  logic [9:0]  x_position = '0;
  logic [8:0]  y_position = '0;
  logic [11:0] color_w, color_n;
  logic [15:0] generation_w, generation_n;
  logic        busy_w, busy_n;

  int tests = 0;
  int fails = 0;
  int cur_x = 320;
  int cur_y = 240;

  always #5 clock = ~clock;

  life_engine #(.GEN_DIV(4), .WRAP(1)) dut_w (
    .clock(clock), .reset_n(reset_n), .run(run), .step(step), .clear(clear),
    .pointer_ready(pointer_ready), .pointer_delta_x(pointer_delta_x), .pointer_delta_y(pointer_delta_y),
    .pointer_select(pointer_select), .x_position(x_position), .y_position(y_position),
    .inside_video(inside_video), .color(color_w), .generation(generation_w), .busy(busy_w)
  );

  life_engine #(.GEN_DIV(4), .WRAP(0)) dut_n (
    .clock(clock), .reset_n(reset_n), .run(run), .step(step), .clear(clear),
    .pointer_ready(pointer_ready), .pointer_delta_x(pointer_delta_x), .pointer_delta_y(pointer_delta_y),
    .pointer_select(pointer_select), .x_position(x_position), .y_position(y_position),
    .inside_video(inside_video), .color(color_n), .generation(generation_n), .busy(busy_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_step();
    step = 1'b1; tick(1); step = 1'b0; tick(2);
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(1); clear = 1'b0; tick(30);
  endtask

  task automatic pulse_select();
    pointer_select = 1'b1; tick(1); pointer_select = 1'b0; tick(1);
  endtask

  task automatic move_by(input int dx, input int dy);
    int ax, ay;
    ax = (dx < 0) ? -dx : dx;
    ay = (dy < 0) ? -dy : dy;
    pointer_delta_x = {(dx < 0), ax[7:0]};
    pointer_delta_y = {(dy < 0), ay[7:0]};
    pointer_ready = 1'b1; tick(1); pointer_ready = 1'b0;
    cur_x = cur_x + dx; cur_y = cur_y + dy;
    if (cur_x < 0) cur_x = 0;
    if (cur_x > 639) cur_x = 639;
    if (cur_y < 0) cur_y = 0;
    if (cur_y > 479) cur_y = 479;
  endtask

  task automatic move_to(input int cx, input int cy);
    int tx, ty, dx, dy;
    tx = cx * 20 + 10;
    ty = cy * 20 + 10;
    while (cur_x != tx || cur_y != ty) begin
      dx = tx - cur_x; dy = ty - cur_y;
      if (dx > 255) dx = 255;
      if (dx < -255) dx = -255;
      if (dy > 255) dy = 255;
      if (dy < -255) dy = -255;
      move_by(dx, dy);
    end
  endtask

  task automatic read_cell(input int cx, input int cy, output logic [11:0] cw, output logic [11:0] cn);
    x_position = 10'(cx * 20 + 10);
    y_position = 9'(cy * 20 + 10);
    inside_video = 1'b1;
    tick(1);
    cw = color_w; cn = color_n;
    inside_video = 1'b0;
  endtask

  task automatic check_cell(input string tag, input int cx, input int cy,
                            input logic [11:0] exp_w, input logic [11:0] exp_n);
    logic [11:0] cw, cn;
    read_cell(cx, cy, cw, cn);
    check($sformatf("%s_w(%0d,%0d)", tag, cx, cy), 32'(cw), 32'(exp_w));
    check($sformatf("%s_n(%0d,%0d)", tag, cx, cy), 32'(cn), 32'(exp_n));
  endtask

  task automatic wait_gen_change(output int cycles);
    logic [15:0] old;
    old = generation_w;
    cycles = 0;
    while (generation_w == old && cycles < 50) begin
      tick(1);
      cycles++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gx[5] = '{2, 3, 1, 2, 3};
    int gy[5] = '{1, 2, 3, 3, 3};
    int cyc, n, bad;
    logic [15:0] g;
    logic [11:0] cw, cn, ex;

    tick(3);
    reset_n = 1'b1;
    tick(1);
    check("reset_gen_w", 32'(generation_w), 0);
    check("reset_gen_n", 32'(generation_n), 0);
    check("reset_busy", 32'(busy_w), 0);
    check("reset_color", 32'(color_w), 0);
    check_cell("glider0", 1, 0, LIVE, LIVE);
    check_cell("glider0", 2, 2, LIVE, LIVE);
    check_cell("empty0", 0, 0, EMPTY, EMPTY);
    check_cell("cursor0", 16, 12, PTR, PTR);

    repeat (4) pulse_step();
    check("step4_gen_w", 32'(generation_w), 4);
    check("step4_gen_n", 32'(generation_n), 4);
    for (int i = 0; i < 5; i++) check_cell("glider4", gx[i], gy[i], LIVE, LIVE);
    check_cell("glider4_gone", 1, 0, EMPTY, EMPTY);
    check_cell("glider4_gone", 2, 2, EMPTY, EMPTY);
    x_position = 10'd700; y_position = 9'd10; inside_video = 1'b1; tick(1);
    check("beyond_grid", 32'(color_w), 0);
    x_position = 10'd50; y_position = 9'd30; inside_video = 1'b0; tick(1);
    check("outside_video", 32'(color_w), 0);

    run = 1'b1;
    wait_gen_change(cyc);
    check("run_first_update", cyc, 5);
    wait_gen_change(cyc);
    check("run_period", cyc, 4);
    tick(1);
    run = 1'b0;
    tick(1);
    g = generation_w;
    tick(20);
    check("run_stop_gen", 32'(generation_w), 6);
    check("run_stop_hold", 32'(generation_w), 32'(g));

    run = 1'b1;
    tick(2);
    clear = 1'b1; tick(1); clear = 1'b0;
    n = 0;
    while (busy_w && n < 100) begin
      n++;
      if (n == 5) run = 1'b0;
      pointer_select = (n == 20);
      tick(1);
    end
    pointer_select = 1'b0;
    check("clear_busy_cycles", n, 24);
    check("clear_gen_w", 32'(generation_w), 0);
    check("clear_gen_n", 32'(generation_n), 0);
    tick(10);
    check("clear_idle_gen", 32'(generation_w), 0);
    bad = 0;
    for (int y = 0; y < 24; y++) begin
      for (int x = 0; x < 32; x++) begin
        read_cell(x, y, cw, cn);
        ex = (x == 16 && y == 12) ? PTR : EMPTY;
        if (cw !== ex) bad++;
        if (cn !== ex) bad++;
      end
    end
    check("clear_scan_bad", bad, 0);

    move_to(5, 5);  pulse_select();
    move_to(6, 5);  pulse_select();
    move_to(7, 5);  pulse_select();
    check_cell("toggled", 5, 5, LIVE, LIVE);
    pulse_step();
    check_cell("blink1", 6, 4, LIVE, LIVE);
    check_cell("blink1", 6, 5, LIVE, LIVE);
    check_cell("blink1", 6, 6, LIVE, LIVE);
    check_cell("blink1_dead", 5, 5, EMPTY, EMPTY);
    check_cell("blink1_cursor", 7, 5, PTR, PTR);
    pulse_step();
    check_cell("blink2", 5, 5, LIVE, LIVE);
    check_cell("blink2", 7, 5, LIVE, LIVE);
    check_cell("blink2_dead", 6, 4, EMPTY, EMPTY);
    check("blink_gen", 32'(generation_w), 2);

    pulse_clear();
    move_to(31, 5); pulse_select();
    move_to(31, 6); pulse_select();
    move_to(31, 7); pulse_select();
    pulse_step();
    check_cell("edge1_col0", 0, 6, LIVE, EMPTY);
    check_cell("edge1", 30, 6, LIVE, LIVE);
    check_cell("edge1", 31, 6, LIVE, LIVE);
    check_cell("edge1_dead", 31, 5, EMPTY, EMPTY);
    check_cell("edge1_cursor", 31, 7, PTR, PTR);
    check("edge_gen", 32'(generation_n), 1);
    pulse_step();
    check_cell("edge2_col0", 0, 6, EMPTY, EMPTY);
    check_cell("edge2", 31, 6, LIVE, EMPTY);
    check_cell("edge2", 31, 7, LIVE, PTR);

    repeat (3) move_by(-255, 0);
    move_by(20, 0);
    check_cell("clamp_x0", 1, 7, PTR, PTR);
    check_cell("clamp_x0_left", 0, 7, EMPTY, EMPTY);
    repeat (3) move_by(255, 0);
    move_by(-20, 0);
    check_cell("clamp_xmax", 30, 7, PTR, PTR);
    repeat (2) move_by(0, -255);
    move_by(0, 20);
    check_cell("clamp_y0", 30, 1, PTR, PTR);
    repeat (2) move_by(0, 255);
    move_by(0, -20);
    check_cell("clamp_ymax", 30, 22, PTR, PTR);

    pulse_clear();
    move_to(10, 10); pulse_select();
    move_to(11, 10); pulse_select();
    move_to(10, 11); pulse_select();
    move_to(11, 11); pulse_select();
    run = 1'b1;
    tick(20);
`ifdef LIFE_AUTO_STOP_EN
    check("block_gen_a", 32'(generation_w), 1);
    tick(20);
    check("block_gen_b", 32'(generation_w), 1);
`else
    check("block_gen_a", 32'(generation_w), 4);
    tick(20);
    check("block_gen_b", 32'(generation_w), 9);
`endif
    run = 1'b0;
    tick(2);
    check_cell("block", 10, 10, LIVE, LIVE);
    check_cell("block", 11, 11, LIVE, LIVE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
